// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the GPR write port between the ALU (port 0) and the
// multi-cycle unit (port 1), and tracks pending multi-cycle writes in a busy
// scoreboard that stalls hazardous issues.
// Optional macro GPR_ARB_STATS_EN adds grant and conflict counters.
module gpr_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_v0,
    input  logic [4:0]        i_reg0,
    input  logic [DATA_W-1:0] i_data0,
    output logic              o_rdy0,
    input  logic              i_v1,
    input  logic [4:0]        i_reg1,
    input  logic [DATA_W-1:0] i_data1,
    output logic              o_rdy1,
    input  logic              i_issue,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [4:0]        i_rd,
    output logic              o_stall,
    output logic              o_wen,
    output logic [4:0]        o_wreg,
    output logic [DATA_W-1:0] o_wdata,
    output logic [31:0]       o_busy
`ifdef GPR_ARB_STATS_EN
    ,
    output logic [31:0]       o_cnt0,
    output logic [31:0]       o_cnt1,
    output logic [31:0]       o_conf_cnt
`endif
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]        r_wait;
    logic              r_wen;
    logic [4:0]        r_wreg;
    logic [DATA_W-1:0] r_wdata;
    logic [31:0]       r_busy;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_stall;
    logic              w_set;
    logic [4:0]        w_greg;
    logic [DATA_W-1:0] w_gdata;
    logic [3:0]        w_wait_nxt;
    logic [31:0]       w_busy_nxt;

    // Arbitration: port 0 wins unless port 1 has aged out; nothing granted in reset.
    always_comb begin
        w_gnt1  = 1'b0;
        w_gnt0  = 1'b0;
        w_greg  = i_reg0;
        w_gdata = i_data0;
        if (!rst) begin
            w_gnt1 = i_v1 && (!i_v0 || (r_wait == LP_MAX_WAIT));
            w_gnt0 = i_v0 && !w_gnt1;
        end
        if (w_gnt1) begin
            w_greg  = i_reg1;
            w_gdata = i_data1;
        end
    end

    // Wait counter next state: counts refused port-1 cycles, saturating.
    always_comb begin
        w_wait_nxt = r_wait;
        if (!i_v1 || w_gnt1) begin
            w_wait_nxt = 4'd0;
        end else if (r_wait != LP_MAX_WAIT) begin
            w_wait_nxt = r_wait + 4'd1;
        end
    end

    // Hazard stall and scoreboard next state; a set on the same edge beats a clear.
    always_comb begin
        w_stall    = i_issue && (r_busy[i_rs1] | r_busy[i_rs2] | r_busy[i_rd]);
        w_set      = i_issue && !w_stall && (i_rd != 5'd0);
        w_busy_nxt = r_busy;
        if (w_gnt1) begin
            w_busy_nxt[i_reg1] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[i_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // State: write-port register, wait counter and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait  <= 4'd0;
            r_wen   <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= '0;
            r_busy  <= 32'd0;
        end else begin
            r_wait <= w_wait_nxt;
            r_busy <= w_busy_nxt;
            if (w_gnt0 || w_gnt1) begin
                // Writes to r0 are accepted but never reach the register file.
                r_wen   <= (w_greg != 5'd0);
                r_wreg  <= w_greg;
                r_wdata <= w_gdata;
            end else begin
                r_wen <= 1'b0;
            end
        end
    end

`ifdef GPR_ARB_STATS_EN
    logic [31:0] r_cnt0;
    logic [31:0] r_cnt1;
    logic [31:0] r_conf_cnt;

    // Statistics: per-port grants and contention cycles, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0     <= 32'd0;
            r_cnt1     <= 32'd0;
            r_conf_cnt <= 32'd0;
        end else begin
            if (w_gnt0) r_cnt0 <= r_cnt0 + 32'd1;
            if (w_gnt1) r_cnt1 <= r_cnt1 + 32'd1;
            if (i_v0 && i_v1) r_conf_cnt <= r_conf_cnt + 32'd1;
        end
    end

    assign o_cnt0     = r_cnt0;
    assign o_cnt1     = r_cnt1;
    assign o_conf_cnt = r_conf_cnt;
`endif

    assign o_rdy0  = w_gnt0;
    assign o_rdy1  = w_gnt1;
    assign o_stall = w_stall;
    assign o_wen   = r_wen;
    assign o_wreg  = r_wreg;
    assign o_wdata = r_wdata;
    assign o_busy  = r_busy;

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single write port of the 32x32 general-purpose register file between two writeback requesters:
  - port 0: single-cycle ALU result.
  - port 1: multi-cycle unit result (load/mult/div).
- Keeps a busy scoreboard of destination registers with an outstanding multi-cycle write.
- Raises an issue stall on RAW/WAW hazards against that scoreboard.
- Sits between the execute/writeback units and the GPR's i_wen/i_wreg/i_wdata inputs.

Parameters:
- MAX_WAIT, 3, consecutive cycles port 1 may be refused before it gets forced priority; legal range 1..15.
- DATA_W, 32, writeback data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- i_v0  input  1  port 0 write request valid.
- i_reg0  input  5  port 0 destination register.
- i_data0  input  DATA_W  port 0 write data.
- o_rdy0  output  1  port 0 accepted this cycle.
- i_v1  input  1  port 1 write request valid.
- i_reg1  input  5  port 1 destination register.
- i_data1  input  DATA_W  port 1 write data.
- o_rdy1  output  1  port 1 accepted this cycle.
- i_issue  input  1  decode is issuing a multi-cycle op.
- i_rs1  input  5  source register 1 of the issuing op.
- i_rs2  input  5  source register 2 of the issuing op.
- i_rd  input  5  destination register of the issuing op.
- o_stall  output  1  issue blocked by hazard.
- o_wen  output  1  GPR write enable (registered).
- o_wreg  output  5  GPR write register (registered).
- o_wdata  output  DATA_W  GPR write data (registered).
- o_busy  output  32  scoreboard; bit n set means register n has a pending port-1 write.

Behaviour:
- Reset (rst=1 at posedge):
  - o_wen=0, o_wreg=0, o_wdata=0, o_busy=0.
  - Wait counter cleared.
  - Reset mid-transfer discards any pending grant; no write is issued.
- Arbitration (combinational):
  - Default: port 0 has priority.
  - Port 1 is granted if i_v1 and (!i_v0 or wait_cnt==MAX_WAIT).
  - Port 0 is granted if i_v0 and port 1 is not granted.
  - o_rdy0 and o_rdy1 equal the respective grants; never both 1.
  - A requester holds valid, reg and data stable until it sees rdy.
- Wait counter (4 bits):
  - Increments when i_v1 is high and port 1 is not granted, saturating at MAX_WAIT.
  - Clears on a port-1 grant or when i_v1=0.
- Write output, latency 1:
  - On the posedge where a grant occurs, o_wen<=1, o_wreg<=granted reg, o_wdata<=granted data.
  - Otherwise o_wen<=0; o_wreg/o_wdata hold their previous values.
  - The GPR commits on the following negedge.
- Register 0:
  - A request to reg 0 is still granted (rdy=1) but o_wen stays 0.
  - Scoreboard bit 0 is never set.
- Scoreboard:
  - On posedge with i_issue && !o_stall && i_rd!=0: set busy[i_rd].
  - On posedge with a port-1 grant: clear busy[i_reg1].
  - Same edge, same register, set and clear: set wins (new producer).
  - Port-0 grants never touch the scoreboard.
- Stall:
  - o_stall = i_issue && (busy[i_rs1] | busy[i_rs2] | busy[i_rd]).
  - Purely combinational from current o_busy.
  - A stalled issue records nothing.
  - Because a bit clears on the grant edge, a stalled consumer is released in the same cycle o_wen is high; the GPR write at that negedge makes the data readable within the cycle.
- Port-1 write to a non-busy register: performed normally; scoreboard unchanged.

Optional Feature:
- GPR_ARB_STATS_EN defined:
  - Adds outputs o_cnt0 and o_cnt1 (32 bits each): grants per port.
  - Adds output o_conf_cnt (32 bits): cycles with i_v0 && i_v1.
  - All three reset to 0 and wrap on overflow.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with both ports valid → o_wen=0, o_busy=0, o_rdy0=o_rdy1=0 during reset; first grant goes to port 0 after release.
- Single write: i_v0=1, i_reg0=5, i_data0=32'hDEADBEEF for 1 cycle → o_rdy0=1; next cycle o_wen=1, o_wreg=5, o_wdata=DEADBEEF; GPR r5 reads DEADBEEF after the negedge.
- Aging: i_v0 held 1 continuously, i_v1=1 with i_reg1=7, MAX_WAIT=3 → port 0 granted 3 cycles, then o_rdy1=1 on the 4th; wait_cnt returns to 0.
- Scoreboard hazard: issue with rd=9 → busy[9]=1; next issue with rs1=9 → o_stall=1; port-1 write to reg 9 granted → busy[9]=0 and o_stall drops that cycle.
- Set/clear collision: port-1 grant to reg 12 on the same edge as an unstalled issue with rd=12 → busy[12] remains 1.
- Reg 0: i_v0=1, i_reg0=0 → o_rdy0=1, o_wen stays 0; an issue with rd=0 leaves o_busy=0.
